// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for an 8:1 mux: steps the selects through channels 0..7, holds each
// for DWELL cycles, samples the mux output at the end of each dwell and emits a frame.
module mux_scan_ctrl #(
  parameter int unsigned DWELL = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       cont,
  input  logic       stop,
  input  logic       mux_in,
  output logic       s1,
  output logic       s2,
  output logic       s3,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       busy,
  output logic [7:0] frame_cnt
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state_q, state_d;
  logic [2:0]       ch_q, ch_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [6:0]       shadow_q, shadow_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic [7:0]       frame_q, frame_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ch_q     <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      frame_q  <= '0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      frame_q  <= frame_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    frame_d  = frame_q;

    unique case (state_q)
      IDLE: begin
        ch_d = '0;
        if (start && !stop) begin
          state_d = SCAN;
          cnt_d   = '0;
        end
      end
      SCAN: begin
        // Abort outranks the frame-end path: the partial frame is simply dropped.
        if (stop) begin
          state_d = IDLE;
          ch_d    = '0;
          cnt_d   = '0;
        end else if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else if (ch_q != 3'd7) begin
          for (int unsigned k = 0; k < 7; k++) begin
            if (ch_q == 3'(k)) shadow_d[k] = mux_in;
          end
          cnt_d = '0;
          ch_d  = ch_q + 3'd1;
        end else begin
          data_d  = {mux_in, shadow_q};
          valid_d = 1'b1;
          frame_d = frame_q + 8'd1;
          ch_d    = '0;
          cnt_d   = '0;
          if (!cont) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign {s1, s2, s3} = ch_q;
  assign data_out     = data_q;
  assign valid        = valid_q;
  assign busy         = (state_q == SCAN);
  assign frame_cnt    = frame_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: a DWELL=4 instance checked every cycle against a frame-timeline
// model, plus a DWELL=1 instance checked through the vector table.
module tb_mux_scan_ctrl;

  localparam int unsigned D = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, cont, stop;
  logic       start_f, cont_f, stop_f;
  logic [7:0] pat;

  logic       s1, s2, s3, valid, busy, mux_in;
  logic [7:0] data_out, frame_cnt;
  logic       s1_f, s2_f, s3_f, valid_f, busy_f, mux_in_f;
  logic [7:0] data_out_f, frame_cnt_f;

  always #5 clk = ~clk;

  // Behavioural mux8x1: i1 (select 000) is pat[0].
  assign mux_in   = pat[{s1, s2, s3}];
  assign mux_in_f = pat[{s1_f, s2_f, s3_f}];

  mux_scan_ctrl #(.DWELL(D), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .stop(stop), .mux_in(mux_in),
    .s1(s1), .s2(s2), .s3(s3), .data_out(data_out), .valid(valid), .busy(busy),
    .frame_cnt(frame_cnt)
  );

  mux_scan_ctrl #(.DWELL(1), .CNT_W(8)) dut_f (
    .clk(clk), .rst(rst), .start(start_f), .cont(cont_f), .stop(stop_f), .mux_in(mux_in_f),
    .s1(s1_f), .s2(s2_f), .s3(s3_f), .data_out(data_out_f), .valid(valid_f), .busy(busy_f),
    .frame_cnt(frame_cnt_f)
  );

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Model: a scan is a timeline of 8*D cycles; channel = elapsed / D.
  bit          m_busy;
  int unsigned m_t;
  logic [7:0]  m_bits, m_data, m_frames;
  bit          m_valid;

  function automatic logic [2:0] m_ch();
    return m_busy ? 3'(m_t / D) : 3'd0;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_t = 0; m_bits = '0; m_data = '0; m_frames = '0; m_valid = 0;
  endtask

  task automatic model_step();
    m_valid = 0;
    if (rst) begin
      model_reset();
    end else if (!m_busy) begin
      if (start && !stop) begin
        m_busy = 1;
        m_t    = 0;
      end
    end else if (stop) begin
      m_busy = 0;
    end else begin
      if (m_t % D == D - 1) m_bits[m_t / D] = pat[m_t / D];
      if (m_t == 8 * D - 1) begin
        m_data   = m_bits;
        m_valid  = 1;
        m_frames = m_frames + 8'd1;
        m_t      = 0;
        m_busy   = cont;
      end else begin
        m_t = m_t + 1;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("cycle {sel,busy,valid,data,frame}",
          {11'b0, s1, s2, s3, busy, valid, data_out, frame_cnt},
          {11'b0, m_ch(), m_busy, m_valid, m_data, m_frames});
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_main"}, {11'b0, s1, s2, s3, busy, valid, data_out, frame_cnt}, 32'd0);
    check({name, "_fast"}, {11'b0, s1_f, s2_f, s3_f, busy_f, valid_f, data_out_f, frame_cnt_f}, 32'd0);
  endtask

  typedef struct {
    logic [7:0]  pat;
    bit          fast;
    logic [7:0]  exp_data;
    int unsigned exp_lat;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int unsigned n, cyc, nv, last_v, f0;
    logic [7:0] d0;

    vecs[0] = '{8'h55, 1'b0, 8'h55, 32};
    vecs[1] = '{8'hAA, 1'b0, 8'hAA, 32};
    vecs[2] = '{8'h3C, 1'b0, 8'h3C, 32};
    vecs[3] = '{8'h81, 1'b0, 8'h81, 32};
    vecs[4] = '{8'h55, 1'b1, 8'h55, 8};
    vecs[5] = '{8'hFF, 1'b1, 8'hFF, 8};
    vecs[6] = '{8'h0E, 1'b1, 8'h0E, 8};

    // Asynchronous reset before the first clock edge.
    rst = 1; start = 0; cont = 0; stop = 0; start_f = 0; cont_f = 0; stop_f = 0; pat = '0;
    model_reset();
    #1;
    check_all_zero("reset_async");
    tick();
    rst = 0;
    tick();

    // Table: single scans.
    foreach (vecs[i]) begin
      pat = vecs[i].pat;
      if (!vecs[i].fast) begin
        start = 1; tick(); start = 0;
        n = 0;
        do begin tick(); n++; end while (!valid && n < 100);
        check("table_lat", n, vecs[i].exp_lat);
        check("table_data", data_out, vecs[i].exp_data);
        check("table_end_idle", {s1, s2, s3, busy}, 4'b0000);
      end else begin
        start_f = 1; tick(); start_f = 0;
        n = 0;
        do begin tick(); n++; end while (!valid_f && n < 100);
        check("fast_lat", n, vecs[i].exp_lat);
        check("fast_data", data_out_f, vecs[i].exp_data);
        check("fast_end_idle", {s1_f, s2_f, s3_f, busy_f}, 4'b0000);
      end
      tick();
      check("valid_one_cycle", {valid, valid_f}, 2'b00);
    end
    check("fast_frames", frame_cnt_f, 8'd3);

    // Continuous frames, cont dropped part-way through frame 3.
    pat = 8'hF0; cont = 1; f0 = frame_cnt;
    start = 1; tick(); start = 0;
    cyc = 0; nv = 0; last_v = 0;
    do begin
      tick(); cyc++;
      if (valid) begin
        nv++;
        check("cont_data", data_out, 8'hF0);
        check("cont_spacing", cyc - last_v, 32);
        last_v = cyc;
      end
      if (cyc == 74) cont = 0;
    end while (busy && cyc < 200);
    check("cont_frames", nv, 3);
    check("cont_end_cycle", cyc, 96);
    check("cont_frame_cnt", frame_cnt, 8'(f0 + 3));

    // Abort mid-scan.
    f0 = frame_cnt; d0 = data_out; pat = 8'h5A;
    start = 1; tick(); start = 0;
    repeat (12) tick();
    stop = 1; tick(); stop = 0;
    check("abort_idle", {s1, s2, s3, busy, valid}, 5'b0);
    check("abort_data", data_out, d0);
    check("abort_frames", frame_cnt, f0);
    nv = 0;
    repeat (40) begin tick(); if (valid) nv++; end
    check("abort_no_valid", nv, 0);

    // start and stop together in IDLE.
    start = 1; stop = 1; tick(); start = 0; stop = 0;
    check("start_stop_idle", busy, 1'b0);
    tick();
    check("start_stop_idle2", busy, 1'b0);

    // start while busy is ignored.
    pat = 8'h96;
    start = 1; tick(); start = 0;
    repeat (9) tick();
    start = 1; tick(); start = 0;
    n = 10;
    do begin tick(); n++; end while (!valid && n < 100);
    check("restart_ignored_lat", n, 32);
    check("restart_ignored_data", data_out, 8'h96);

    // Reset mid-scan takes effect without a clock edge.
    start = 1; tick(); start = 0;
    repeat (20) tick();
    rst = 1; model_reset();
    #1;
    check_all_zero("reset_midscan");
    tick();
    rst = 0;
    tick();

    // 256 continuous frames with a changing input pattern: frame counter wraps to 0.
    cont = 1; start = 1; pat = 8'($urandom); tick(); start = 0;
    nv = 0; cyc = 0;
    while (nv < 256 && cyc < 256 * 32 + 100) begin
      pat = 8'($urandom);
      tick(); cyc++;
      if (valid) nv++;
    end
    check("wrap_frames", nv, 256);
    check("wrap_frame_cnt", frame_cnt, 8'd0);
    cont = 0;
    cyc = 0;
    while (busy && cyc < 100) begin tick(); cyc++; end
    check("wrap_stopped", busy, 1'b0);

    // Random control traffic.
    repeat (3000) begin
      pat   = 8'($urandom);
      start = ($urandom % 4) == 0;
      cont  = ($urandom % 2) == 0;
      stop  = ($urandom % 80) == 0;
      tick();
    end
    start = 0; stop = 0; cont = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
Name: mux_scan_ctrl

Overview:
- Sequencer directly upstream of the 8:1 mux (mux8x1). Drives its select lines s1/s2/s3 through channels 0..7 and holds each channel for a programmable dwell time.
- Samples the mux output `out` at the end of each dwell and packs the eight samples into a parallel frame word.
- Presents the frame with a one-cycle valid strobe. Supports single-shot and continuous scanning, plus abort.

Parameters:
- DWELL, 4, cycles each channel is held before sampling; legal range 1..255.
- CNT_W, 8, width of the dwell counter; must hold DWELL-1.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a scan; sampled only in IDLE.
- cont  input  1  continuous mode; sampled at end of each frame.
- stop  input  1  synchronous abort.
- mux_in  input  1  connects to mux8x1 `out`.
- s1  output  1  select MSB, to mux8x1 s1.
- s2  output  1  select middle bit, to mux8x1 s2.
- s3  output  1  select LSB, to mux8x1 s3.
- data_out  output  8  last complete frame; bit k = sample of channel k (code 000 = i1 = bit 0).
- valid  output  1  one-cycle strobe, data_out updated.
- busy  output  1  high while scanning.
- frame_cnt  output  8  completed-frame counter; wraps 255->0.

Behaviour:
- Reset (async, any state): state=IDLE, {s1,s2,s3}=000, data_out=0, valid=0, busy=0, frame_cnt=0, internal shadow/ch/cnt=0.
- All outputs are registered. {s1,s2,s3} = ch[2:0], with s1 = ch[2].
- States are IDLE and SCAN only.
- IDLE:
  - busy=0 and select holds 000.
  - start=1 and stop=0 at an edge -> SCAN, ch=0, cnt=0.
- SCAN:
  - busy=1.
  - Each edge: if cnt != DWELL-1, cnt++.
  - Else, when ch<7: shadow[ch] <= mux_in, cnt=0, ch++.
  - Else, when ch=7:
    - data_out <= {mux_in, shadow[6:0]}, valid=1 for exactly the next cycle, frame_cnt++.
    - If cont=1: ch=0, cnt=0 and stay in SCAN with no gap cycle.
    - Else: -> IDLE and select returns to 000.
- Timing: with start accepted at edge E0, channel k is sampled at edge E0+DWELL*(k+1). valid is high in the cycle after edge E0+8*DWELL, so latency is 8*DWELL cycles.
- Channel k is driven for exactly DWELL cycles. The mux is combinational; no extra settle cycle is required.
- stop:
  - stop=1 in SCAN -> IDLE at the next edge. Partial frame discarded: data_out and frame_cnt unchanged, valid=0.
  - stop has priority over the frame-end actions in the same cycle, so no valid is generated.
- start while busy is ignored. start and stop together in IDLE: stop wins, so the block stays IDLE.
- cont is examined only at frame end. Deasserting cont mid-frame finishes the current frame, then the block goes IDLE.
- DWELL=1: channel advances every cycle and a frame takes 8 cycles.
- Reset mid-scan: immediate return to reset values. A frame never completes across reset.

Test Plan:
- Reset: assert rst with all inputs X/0 -> s1..s3=000, data_out=0x00, valid=0, busy=0, frame_cnt=0, all asynchronous with no clock edge needed.
- Single scan, DWELL=4: mux8x1 inputs i1..i8=1,0,1,0,1,0,1,0, pulse start -> select steps 000..111, 4 cycles each; valid pulses once 32 cycles after start; data_out=0x55; frame_cnt=1; busy falls with valid; select returns to 000.
- Continuous: cont=1, inputs i1..i8=0,0,0,0,1,1,1,1 -> valid every 32 cycles with no gap; data_out=0xF0 each frame; frame_cnt increments per frame. Drop cont mid-frame 3 -> frame 3 completes and the block returns to IDLE.
- Abort: start, assert stop on cycle 13 -> next edge IDLE, busy=0, select=000, no valid, data_out keeps the prior value, frame_cnt unchanged.
- Simultaneous/ignored: start and stop in the same IDLE cycle -> stays IDLE; start pulsed while busy -> no restart, frame completes at the original 32-cycle point.
- Reset mid-operation and wrap: assert rst at cycle 20 of a scan -> all outputs reset immediately. Run 256 continuous frames -> frame_cnt wraps to 0. Repeat the single scan with DWELL=1 -> valid at 8 cycles, data_out=0x55.
